// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter between pipeline write-back and a long-latency FIFO
module rf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_en,
    input  logic [3:0]               pipe_addr,
    input  logic [31:0]              pipe_data,
    input  logic                     mc_valid,
    input  logic [3:0]               mc_addr,
    input  logic [31:0]              mc_data,
    output logic                     mc_ready,
    output logic                     rf_we,
    output logic [3:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     stall_req,
    output logic [15:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [3:0]       mem_addr [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WW-1:0]    wait_cnt;

    logic fifo_ne;
    logic push;
    logic grant_fifo;
    logic grant_pipe;

    assign fifo_ne   = (q_count != '0);
    assign mc_ready  = !rst && (q_count < CW'(DEPTH));
    assign push      = mc_valid && mc_ready;
    assign stall_req = (wait_cnt == WW'(MAX_WAIT));

    // A starved head preempts the pipeline; otherwise the FIFO only drains in idle slots.
    assign grant_fifo = fifo_ne && (stall_req || !pipe_en);
    assign grant_pipe = pipe_en && !grant_fifo;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                busy_mask[mem_addr[i]] = 1'b1;
            end
        end
    end

    // Payload storage needs no reset; the valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_addr[wr_ptr] <= mc_addr;
            mem_data[wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            valid    <= '0;
            wait_cnt <= '0;
        end else begin
            rf_we <= grant_fifo || grant_pipe;
            if (grant_fifo) begin
                rf_waddr      <= mem_addr[rd_ptr];
                rf_wdata      <= mem_data[rd_ptr];
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end else if (grant_pipe) begin
                rf_waddr <= pipe_addr;
                rf_wdata <= pipe_data;
            end

            // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end

            case ({push, grant_fifo})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase

            if (!fifo_ne || grant_fifo) begin
                wait_cnt <= '0;
            end else if (grant_pipe && !stall_req) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_en;
    logic [3:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [3:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [15:0] busy_mask;
    logic [1:0]  q_count;

    int checks   = 0;
    int failures = 0;
    int unexpected = 0;
    logic [35:0] exp_q[$];

    rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_en   (pipe_en),
        .pipe_addr (pipe_addr),
        .pipe_data (pipe_data),
        .mc_valid  (mc_valid),
        .mc_addr   (mc_addr),
        .mc_data   (mc_data),
        .mc_ready  (mc_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .stall_req (stall_req),
        .busy_mask (busy_mask),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pe, input logic [3:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md);
        pipe_en   = pe;
        pipe_addr = pa;
        pipe_data = pd;
        mc_valid  = mv;
        mc_addr   = ma;
        mc_data   = md;
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Every register-file write must match the next expected write in grant order.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                unexpected++;
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check("sb_addr", {28'd0, rf_waddr}, {28'd0, e[35:32]});
                check("sb_data", rf_wdata, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
        step();
        step();
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_qcount", q_count, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_stall", stall_req, 0);
        check("rst_ready", mc_ready, 0);
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        check("post_rst_we", rf_we, 0);
        check("post_rst_qcount", q_count, 0);
        check("post_rst_ready", mc_ready, 1);

        // Pipeline only
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0);
        expect_write(4'd3, 32'hDEADBEEF);
        step();
        check("pipe_we", rf_we, 1);
        check("pipe_waddr", rf_waddr, 3);
        check("pipe_wdata", rf_wdata, 32'hDEADBEEF);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        check("pipe_we_drop", rf_we, 0);
        check("pipe_waddr_hold", rf_waddr, 3);

        // Fill while the pipeline owns the port, then drain in idle slots
        drive(1'b1, 4'd1, 32'h100, 1'b1, 4'd5, 32'h55);
        expect_write(4'd1, 32'h100);
        step();
        drive(1'b1, 4'd1, 32'h101, 1'b1, 4'd9, 32'h99);
        expect_write(4'd1, 32'h101);
        step();
        check("fill_qcount", q_count, 2);
        check("fill_ready", mc_ready, 0);
        check("fill_busy", busy_mask, 32'h0220);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        expect_write(4'd5, 32'h55);
        expect_write(4'd9, 32'h99);
        step();
        check("drain1_waddr", rf_waddr, 5);
        check("drain1_qcount", q_count, 1);
        check("drain1_busy", busy_mask, 32'h0200);
        step();
        check("drain2_we", rf_we, 1);
        check("drain2_waddr", rf_waddr, 9);
        check("drain2_busy", busy_mask, 0);
        step();
        check("drain_idle_we", rf_we, 0);

        // Starvation: head loses four times, then preempts one pipeline cycle
        drive(1'b1, 4'd2, 32'h200, 1'b1, 4'd12, 32'hC0);
        expect_write(4'd2, 32'h200);
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'd2, 32'h200 + i, 1'b0, 4'd0, 32'h0);
            expect_write(4'd2, 32'h200 + i);
            step();
            check($sformatf("starve_stall_%0d", i), stall_req, (i == 4) ? 1 : 0);
        end
        drive(1'b1, 4'd2, 32'h205, 1'b0, 4'd0, 32'h0);
        expect_write(4'd12, 32'hC0);
        step();
        check("stall_head_waddr", rf_waddr, 12);
        check("stall_drop", stall_req, 0);
        expect_write(4'd2, 32'h205);
        step();
        check("stall_replay_wdata", rf_wdata, 32'h205);
        check("stall_after", stall_req, 0);

        // Simultaneous push and pop across pointer wrap
        drive(1'b1, 4'd0, 32'h300, 1'b1, 4'd4, 32'hA1);
        expect_write(4'd0, 32'h300);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd6, 32'hB1);
        expect_write(4'd4, 32'hA1);
        step();
        check("pp1_qcount", q_count, 1);
        check("pp1_busy", busy_mask, 32'h0040);
        drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd8, 32'hC1);
        expect_write(4'd6, 32'hB1);
        step();
        check("pp2_qcount", q_count, 1);
        check("pp2_busy", busy_mask, 32'h0100);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        expect_write(4'd8, 32'hC1);
        step();
        check("pp_empty", q_count, 0);

        // Same-address writes are kept in grant order
        drive(1'b1, 4'd1, 32'h400, 1'b1, 4'd7, 32'h1);
        expect_write(4'd1, 32'h400);
        step();
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        expect_write(4'd7, 32'h1);
        step();
        check("same_q_wdata", rf_wdata, 1);
        drive(1'b1, 4'd7, 32'h2, 1'b0, 4'd0, 32'h0);
        expect_write(4'd7, 32'h2);
        step();
        check("same_p_wdata", rf_wdata, 2);

        // Reset with an entry queued discards it
        drive(1'b1, 4'd10, 32'h500, 1'b1, 4'd11, 32'hBB);
        expect_write(4'd10, 32'h500);
        step();
        check("mid_qcount", q_count, 1);
        check("mid_busy", busy_mask, 32'h0800);
        rst = 1'b1;
        drive(1'b1, 4'd13, 32'h600, 1'b0, 4'd0, 32'h0);
        step();
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_qcount", q_count, 0);
        check("mid_rst_busy", busy_mask, 0);
        check("mid_rst_ready", mc_ready, 0);
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        step();
        check("mid_post_we", rf_we, 0);
        step();
        check("mid_post_we2", rf_we, 0);
        step();

        check("sb_leftover", exp_q.size(), 0);
        check("sb_unexpected", unexpected, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 16×32 register file. It shares the single register-file write port between the in-order pipeline write-back (the RW stage `isEnable` / `reg_write_address` / `reg_write_data` triple) and one long-latency requester, such as a multi-cycle divide unit. Long-latency results are buffered in a small FIFO and drain in pipeline idle slots. A starvation counter forces a one-cycle pipeline stall when the FIFO head has waited too long. The block also exports a pending-write mask for the hazard unit.

## Interface
- DEPTH, 2, FIFO entries for the long-latency requester; power of two, ≥2
- MAX_WAIT, 4, consecutive lost-arbitration cycles before `stall_req` asserts; ≥1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- pipe_en  in  1  pipeline write request (RW-stage isEnable)
- pipe_addr  in  4  pipeline destination register
- pipe_data  in  32  pipeline write data
- mc_valid  in  1  long-latency result valid
- mc_addr  in  4  long-latency destination register
- mc_data  in  32  long-latency result data
- mc_ready  out  1  FIFO can accept this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  4  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- stall_req  out  1  freeze the pipeline; upstream holds `pipe_*` stable while high
- busy_mask  out  16  bit r = 1 when any valid FIFO entry targets register r
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **Enqueue:** happens when `mc_valid && mc_ready`. The entry is written at the tail.
- **mc_ready:** equals `!rst && (q_count < DEPTH)`. It is computed from registered occupancy only, so a same-cycle pop does not raise it.
- **Grant priority for each cycle:**
  1. If `stall_req`=1 and the FIFO is non-empty, grant the FIFO head. Any pipeline write is not performed this cycle and must be re-presented by the stalled upstream.
  2. Else if `pipe_en`=1, grant the pipeline.
  3. Else if the FIFO is non-empty, grant the FIFO head.
  4. Else no write occurs.
- **Grant outputs:** a granted write loads `rf_we`=1 with its address and data at the next edge. With no grant, `rf_we`=0 and `rf_waddr`/`rf_wdata` hold their previous values.
- **Pop:** the FIFO head pops on the edge where it is granted.
- **Simultaneous push and pop:** allowed; occupancy is unchanged.
- **Pointer wrap:** pointers wrap modulo DEPTH.
- **Starvation counter `wait_cnt` (0..MAX_WAIT):**
  - Increments, saturating at MAX_WAIT, when the FIFO is non-empty and the pipeline wins the grant.
  - Clears to 0 when the FIFO head pops or the FIFO is empty.
  - `stall_req` = (`wait_cnt` == MAX_WAIT), combinational from the register.
- **Ordering:** writes reach the register file strictly in grant order.
  - No merging or dropping of writes, including same-address writes from both sources.
  - RAW protection against queued writes is the hazard unit's job, using `busy_mask`.
- **busy_mask:** the OR of one-hot decodes of `mc_addr` over all valid FIFO entries. It is combinational from FIFO state and reflects an enqueue or pop one cycle after the edge that performed it.

## Timing
- **Reset values (rst=1 on an edge):**
  - Outputs: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `q_count`=0, `busy_mask`=0, `stall_req`=0, `mc_ready`=0 while rst is high.
  - Internal state: FIFO pointers = 0, `wait_cnt` = 0.
  - `pipe_en` and `mc_valid` are ignored during reset.
  - A reset mid-operation discards all queued entries with no register-file write.
- **Pipeline latency:** `pipe_en` at cycle N produces `rf_we`=1 in cycle N+1, unless `stall_req` was high in N.
- **Long-latency latency:** an entry accepted at edge N is eligible at cycle N+1 at the earliest, so `rf_we` rises in N+2 at the earliest. There is no bypass around the FIFO.
- **Full FIFO:** `mc_ready`=0; `mc_valid` must be held by the requester.
- **Empty FIFO:** no pop occurs and `wait_cnt` clears.
- **Stall duration:** `stall_req` is high for exactly one cycle per starvation event. It drops the cycle after the head pops, unless the new head immediately starves again after another MAX_WAIT losses.

## Test plan
- **Reset:** rst=1 for 2 cycles with `mc_valid`=1 and `pipe_en`=1 → all outputs 0, `mc_ready`=0, nothing enqueued, no write after release.
- **Pipeline only:** `pipe_en`=1, addr=3, data=0xDEADBEEF at cycle N → `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0xDEADBEEF in N+1; `rf_we`=0 in N+2 if `pipe_en` dropped.
- **Fill and drain:** with `pipe_en`=1, push addr 5 then addr 9 → `q_count`=2, `mc_ready`=0, `busy_mask`=0x0220. Then drop `pipe_en` → two writes, r5 then r9, on consecutive cycles; `busy_mask` returns to 0.
- **Starvation:** one entry queued and `pipe_en` held at 1 → after 4 lost cycles `stall_req`=1 for one cycle. The head is written in the next cycle and the held pipeline write in the cycle after.
- **Simultaneous push and pop:** FIFO at DEPTH-1 with idle pipeline, `mc_valid`=1 → `q_count` is unchanged, pointers wrap past index DEPTH-1, data order is preserved.
- **Same-address ordering:** queued write r7=1, then pipeline write r7=2 in the idle-slot cycle → register-file write sequence follows grant order exactly; there is no merge.
